// File: rtl/sram_word_sequencer.sv
// sram_word_sequencer: splits 32-bit LSU loads/stores into two 16-bit half-accesses
// on an IS61WV25616 SRAM, low half first, with registered pins and optional wait states.
module sram_word_sequencer #(
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [18:0] i_addr,
   input  logic [31:0] i_wdata,
   input  logic [3:0]  i_bmask,
   input  logic        i_wren,
   input  logic        i_rden,
   output logic [31:0] o_rdata,
   output logic        o_ack,
   output logic        o_busy,
   output logic [17:0] SRAM_ADDR,
   inout  wire  [15:0] SRAM_DQ,
   output logic        SRAM_CE_N,
   output logic        SRAM_OE_N,
   output logic        SRAM_WE_N,
   output logic        SRAM_LB_N,
   output logic        SRAM_UB_N
);
   typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;
   localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);
   state_t      state, nxt;
   logic [2:0]  cnt;
   logic [16:0] word, nxt_word;
   logic [31:0] wdata, nxt_wdata;
   logic [3:0]  bmask, nxt_bmask;
   logic [15:0] dq_out;
   logic        dq_oe, last, idle, nrd, nwr, nhi;
   logic [1:0]  nmask;
   logic        unused_ok;
   assign unused_ok = &{1'b0, i_addr[1:0]};
   assign last = cnt == 3'd0;
   assign o_busy = state != IDLE;
   assign SRAM_DQ = dq_oe ? dq_out : 16'bz;
   // Pins are registered from the next state so they change on the entering edge.
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = i_wren ? WR_LO : i_rden ? RD_LO : IDLE;
         RD_LO:   nxt = last ? RD_HI : RD_LO;
         RD_HI:   nxt = last ? DONE : RD_HI;
         WR_LO:   nxt = last ? WR_HI : WR_LO;
         WR_HI:   nxt = last ? DONE : WR_HI;
         default: nxt = IDLE;
      endcase
      idle      = state == IDLE;
      nxt_word  = idle ? i_addr[18:2] : word;
      nxt_wdata = idle ? i_wdata : wdata;
      nxt_bmask = idle ? i_bmask : bmask;
      nrd       = nxt == RD_LO || nxt == RD_HI;
      nwr       = nxt == WR_LO || nxt == WR_HI;
      nhi       = nxt == RD_HI || nxt == WR_HI;
      nmask     = nhi ? nxt_bmask[3:2] : nxt_bmask[1:0];
   end
   always_ff @(posedge i_clk or posedge i_reset)
      if (i_reset) begin
         state     <= IDLE;
         cnt       <= '0;
         word      <= '0;
         wdata     <= '0;
         bmask     <= '0;
         o_rdata   <= '0;
         o_ack     <= 1'b0;
         SRAM_ADDR <= '0;
         SRAM_CE_N <= 1'b1;
         SRAM_OE_N <= 1'b1;
         SRAM_WE_N <= 1'b1;
         SRAM_LB_N <= 1'b1;
         SRAM_UB_N <= 1'b1;
         dq_oe     <= 1'b0;
         dq_out    <= '0;
      end else begin
         state <= nxt;
         cnt   <= nxt != state ? WAIT_INIT : last ? cnt : cnt - 3'd1;
         word  <= nxt_word;
         wdata <= nxt_wdata;
         bmask <= nxt_bmask;
         o_ack <= nxt == DONE;
         if (state == RD_LO && last) o_rdata[15:0] <= SRAM_DQ;
         if (state == RD_HI && last) o_rdata[31:16] <= SRAM_DQ;
         if (nrd || nwr) SRAM_ADDR <= {nxt_word, nhi};
         SRAM_CE_N <= !(nrd || nwr);
         SRAM_OE_N <= !nrd;
         SRAM_WE_N <= !nwr;
         SRAM_LB_N <= nwr ? ~nmask[0] : !nrd;
         SRAM_UB_N <= nwr ? ~nmask[1] : !nrd;
         dq_oe     <= nwr;
         dq_out    <= nhi ? nxt_wdata[31:16] : nxt_wdata[15:0];
      end
endmodule
